// File: rtl/debounce_pkg.sv
// Shared types, default timing and width helpers for the debounce bank.
// Channels and the bank top import this package.
package debounce_pkg;

    localparam int DEFAULT_N      = 4;
    localparam int DEFAULT_DELAY  = 1000000;
    localparam int DEFAULT_HOLD   = 50000000;
    localparam int DEFAULT_REPEAT = 20000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } hold_state_t;

    // Bits needed to hold every value 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_if.sv
// Bundle of raw inputs and conditioned outputs for an N-channel debounce bank.
// master drives the raw inputs; slave is the conditioner side.
interface debounce_if #(
    parameter int N = 4
) ();

    logic [N-1:0] noisy;
    logic [N-1:0] clean;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] held;
    logic [N-1:0] rpt;

    modport master (
        output noisy,
        input  clean, rise, fall, held, rpt
    );

    modport slave (
        input  noisy,
        output clean, rise, fall, held, rpt
    );

endinterface

// File: rtl/debounce_channel.sv
// One switch channel: 2-FF synchroniser, stable-time debounce, edge strobes,
// and a hold/auto-repeat FSM driven by the debounced level.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DELAY     = DEFAULT_DELAY,
    parameter int HOLD      = DEFAULT_HOLD,
    parameter int REPEAT    = DEFAULT_REPEAT,
    parameter bit REPEAT_EN = 1'b1,
    parameter bit RST_VAL   = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic noisy,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic held,
    output logic rpt
);

    localparam int DW = cnt_width(DELAY);
    localparam int HW = cnt_width(max_int(HOLD, REPEAT));

    logic          sync1_q,   sync1_d;
    logic          sync2_q,   sync2_d;
    logic          pending_q, pending_d;
    logic          clean_q,   clean_d;
    logic [DW-1:0] dcnt_q,    dcnt_d;
    logic          rise_q,    rise_d;
    logic          fall_q,    fall_d;
    logic          held_q,    held_d;
    logic          rpt_q,     rpt_d;
    logic [HW-1:0] hcnt_q,    hcnt_d;
    hold_state_t   state_q,   state_d;

    always_comb begin
        sync1_d   = noisy;
        sync2_d   = sync1_q;
        pending_d = pending_q;
        clean_d   = clean_q;
        dcnt_d    = dcnt_q;

        // The count saturates at DELAY so a long-stable input never re-triggers.
        if (sync2_q != pending_q) begin
            pending_d = sync2_q;
            dcnt_d    = '0;
        end else if (dcnt_q == DW'(DELAY)) begin
            clean_d = pending_q;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end

        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
    end

    // The FSM looks at clean_d so held drops on the same edge that fall asserts.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        held_d  = held_q;
        rpt_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise_d) begin
                    state_d = PRESS;
                    hcnt_d  = HW'(1);
                end
            end
            PRESS: begin
                if (!clean_d) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                    held_d  = 1'b0;
                end else if (hcnt_q == HW'(HOLD)) begin
                    state_d = HELD;
                    held_d  = 1'b1;
                    rpt_d   = REPEAT_EN;
                    hcnt_d  = HW'(1);
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            HELD: begin
                if (!clean_d) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                    held_d  = 1'b0;
                end else if (hcnt_q == HW'(REPEAT)) begin
                    rpt_d  = REPEAT_EN;
                    hcnt_d = HW'(1);
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
                held_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= RST_VAL;
            sync2_q   <= RST_VAL;
            pending_q <= RST_VAL;
            clean_q   <= RST_VAL;
            dcnt_q    <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            held_q    <= 1'b0;
            rpt_q     <= 1'b0;
            hcnt_q    <= '0;
            state_q   <= IDLE;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            pending_q <= pending_d;
            clean_q   <= clean_d;
            dcnt_q    <= dcnt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            held_q    <= held_d;
            rpt_q     <= rpt_d;
            hcnt_q    <= hcnt_d;
            state_q   <= state_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign held  = held_q;
    assign rpt   = rpt_q;

endmodule

// File: rtl/debounce_bank.sv
// N independent switch conditioners sharing only clock and reset.
// Each channel is a debounce_channel; outputs are gathered onto the interface.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int DELAY     = DEFAULT_DELAY,
    parameter int HOLD      = DEFAULT_HOLD,
    parameter int REPEAT    = DEFAULT_REPEAT,
    parameter bit REPEAT_EN = 1'b1,
    parameter bit RST_VAL   = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    debounce_if.slave  bus
);

    logic [N-1:0] clean_w;
    logic [N-1:0] rise_w;
    logic [N-1:0] fall_w;
    logic [N-1:0] held_w;
    logic [N-1:0] rpt_w;

    for (genvar i = 0; i < N; i++) begin : g_ch
        debounce_channel #(
            .DELAY     (DELAY),
            .HOLD      (HOLD),
            .REPEAT    (REPEAT),
            .REPEAT_EN (REPEAT_EN),
            .RST_VAL   (RST_VAL)
        ) u_ch (
            .clock (clock),
            .reset (reset),
            .noisy (bus.noisy[i]),
            .clean (clean_w[i]),
            .rise  (rise_w[i]),
            .fall  (fall_w[i]),
            .held  (held_w[i]),
            .rpt   (rpt_w[i])
        );
    end

    assign bus.clean = clean_w;
    assign bus.rise  = rise_w;
    assign bus.fall  = fall_w;
    assign bus.held  = held_w;
    assign bus.rpt   = rpt_w;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: two instances (auto-repeat on / off) share
// the same raw inputs; every output event is matched against hand-timed expectations.
module tb_debounce_bank;

    localparam int N      = 2;
    localparam int DELAY  = 4;
    localparam int HOLD   = 10;
    localparam int REPEAT = 3;

    localparam int K_CLEAN_UP = 0;
    localparam int K_CLEAN_DN = 1;
    localparam int K_RISE     = 2;
    localparam int K_FALL     = 3;
    localparam int K_HELD_ON  = 4;
    localparam int K_HELD_OFF = 5;
    localparam int K_RPT      = 6;

    typedef struct {
        int cyc;
        int dut;
        int ch;
        int kind;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] noisy_drv = 2'b00;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    ev_t        exp_q[$];

    logic [1:0] prev_clean [2] = '{2'b00, 2'b00};
    logic [1:0] prev_held  [2] = '{2'b00, 2'b00};

    debounce_if #(.N(N)) bus_a ();
    debounce_if #(.N(N)) bus_b ();

    assign bus_a.noisy = noisy_drv;
    assign bus_b.noisy = noisy_drv;

    debounce_bank #(
        .N(N), .DELAY(DELAY), .HOLD(HOLD), .REPEAT(REPEAT),
        .REPEAT_EN(1'b1), .RST_VAL(1'b0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    debounce_bank #(
        .N(N), .DELAY(DELAY), .HOLD(HOLD), .REPEAT(REPEAT),
        .REPEAT_EN(1'b0), .RST_VAL(1'b0)
    ) dut_nr (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kindName(input int k);
        case (k)
            K_CLEAN_UP: return "clean_up";
            K_CLEAN_DN: return "clean_dn";
            K_RISE:     return "rise";
            K_FALL:     return "fall";
            K_HELD_ON:  return "held_on";
            K_HELD_OFF: return "held_off";
            K_RPT:      return "rpt";
            default:    return "?";
        endcase
    endfunction

    task automatic pushEv(input int at, input int d, input int ch, input int kind);
        ev_t e;
        e.cyc  = at;
        e.dut  = d;
        e.ch   = ch;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    // Both instances must agree on everything except rpt.
    task automatic expEdge(input int at, input int ch, input bit up);
        for (int d = 0; d < 2; d++) begin
            pushEv(at, d, ch, up ? K_CLEAN_UP : K_CLEAN_DN);
            pushEv(at, d, ch, up ? K_RISE : K_FALL);
        end
    endtask

    task automatic expBoth(input int at, input int ch, input int kind);
        pushEv(at, 0, ch, kind);
        pushEv(at, 1, ch, kind);
    endtask

    task automatic expRpt(input int at, input int ch);
        pushEv(at, 0, ch, K_RPT);
    endtask

    task automatic checkOutput(input int d, input int ch, input int kind);
        int idx;
        idx = -1;
        checks++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].cyc == cyc && exp_q[i].dut == d &&
                exp_q[i].ch == ch && exp_q[i].kind == kind) begin
                idx = i;
            end
        end
        if (idx >= 0) begin
            exp_q.delete(idx);
        end else begin
            errors++;
            $display("[TB] FAIL unexpected_event dut%0d ch%0d: got %s at cycle %0d, want no event",
                     d, ch, kindName(kind), cyc);
        end
    endtask

    // Monitor: turn output activity into events and retire them against the queue.
    always @(negedge clock) begin
        logic [1:0] cl, rs, fl, hd, rp;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                cl = bus_a.clean; rs = bus_a.rise; fl = bus_a.fall;
                hd = bus_a.held;  rp = bus_a.rpt;
            end else begin
                cl = bus_b.clean; rs = bus_b.rise; fl = bus_b.fall;
                hd = bus_b.held;  rp = bus_b.rpt;
            end
            for (int c = 0; c < N; c++) begin
                if (cl[c] === 1'b1 && prev_clean[d][c] !== 1'b1) checkOutput(d, c, K_CLEAN_UP);
                if (cl[c] !== 1'b1 && prev_clean[d][c] === 1'b1) checkOutput(d, c, K_CLEAN_DN);
                if (rs[c] === 1'b1) checkOutput(d, c, K_RISE);
                if (fl[c] === 1'b1) checkOutput(d, c, K_FALL);
                if (hd[c] === 1'b1 && prev_held[d][c] !== 1'b1) checkOutput(d, c, K_HELD_ON);
                if (hd[c] !== 1'b1 && prev_held[d][c] === 1'b1) checkOutput(d, c, K_HELD_OFF);
                if (rp[c] === 1'b1) checkOutput(d, c, K_RPT);
            end
            prev_clean[d] = cl;
            prev_held[d]  = hd;
        end
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc <= cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL missed_event dut%0d ch%0d: got nothing at cycle %0d, want %s",
                         exp_q[i].dut, exp_q[i].ch, exp_q[i].cyc, kindName(exp_q[i].kind));
                exp_q.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic applyStimulus(input logic [1:0] val);
        noisy_drv = val;
    endtask

    task automatic checkLevel(input string name, input logic [1:0] act);
        checks++;
        if (act !== 2'b00) begin
            errors++;
            $display("[TB] FAIL %s: got %b, want 00", name, act);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkLevel({tag, "_clean_a"}, bus_a.clean);
        checkLevel({tag, "_rise_a"},  bus_a.rise);
        checkLevel({tag, "_fall_a"},  bus_a.fall);
        checkLevel({tag, "_held_a"},  bus_a.held);
        checkLevel({tag, "_rpt_a"},   bus_a.rpt);
        checkLevel({tag, "_clean_b"}, bus_b.clean);
        checkLevel({tag, "_rise_b"},  bus_b.rise);
        checkLevel({tag, "_fall_b"},  bus_b.fall);
        checkLevel({tag, "_held_b"},  bus_b.held);
        checkLevel({tag, "_rpt_b"},   bus_b.rpt);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by time %0t, want finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int r;

        step(4);
        checkAllZero("reset");
        reset = 1'b0;
        step(10);

        // Clean press/release: a change driven after edge k lands on edge k+DELAY+4.
        k = cyc;
        applyStimulus(2'b01);
        expEdge(k + 8, 0, 1'b1);
        step(8);
        applyStimulus(2'b00);
        expEdge(k + 16, 0, 1'b0);
        step(14);

        // Glitches sampled DELAY+1 times or fewer must be swallowed.
        applyStimulus(2'b01);
        step(1);
        applyStimulus(2'b00);
        step(12);
        applyStimulus(2'b01);
        step(5);
        applyStimulus(2'b00);
        step(12);

        // DELAY+2 samples is the shortest pulse that gets through.
        k = cyc;
        applyStimulus(2'b01);
        expEdge(k + 8, 0, 1'b1);
        step(6);
        applyStimulus(2'b00);
        expEdge(k + 14, 0, 1'b0);
        step(14);

        k = cyc;
        applyStimulus(2'b01);
        expEdge(k + 8, 0, 1'b1);
        step(7);
        applyStimulus(2'b00);
        expEdge(k + 15, 0, 1'b0);
        step(14);

        // Long hold: held HOLD cycles after rise, rpt at entry then every REPEAT.
        k = cyc;
        applyStimulus(2'b01);
        expEdge(k + 8, 0, 1'b1);
        expBoth(k + 18, 0, K_HELD_ON);
        for (int m = 0; m < 10; m++) expRpt(k + 18 + 3 * m, 0);
        step(40);
        applyStimulus(2'b00);
        expEdge(k + 48, 0, 1'b0);
        expBoth(k + 48, 0, K_HELD_OFF);
        step(14);

        // Opposite transitions on the same edge.
        k = cyc;
        applyStimulus(2'b10);
        expEdge(k + 8, 1, 1'b1);
        step(9);
        k = cyc;
        applyStimulus(2'b01);
        expEdge(k + 8, 0, 1'b1);
        expEdge(k + 8, 1, 1'b0);
        expBoth(k + 18, 0, K_HELD_ON);
        expRpt(k + 18, 0);
        expRpt(k + 21, 0);
        step(22);

        // Async reset between edges while channel 0 is in HELD.
        #1;
        expBoth(cyc, 0, K_CLEAN_DN);
        expBoth(cyc, 0, K_HELD_OFF);
        reset = 1'b1;
        #1;
        checkAllZero("midheld_reset");
        step(2);
        reset = 1'b0;
        r = cyc;
        expEdge(r + 8, 0, 1'b1);
        step(9);
        applyStimulus(2'b00);
        expEdge(r + 17, 0, 1'b0);
        step(14);

        foreach (exp_q[i]) begin
            checks++;
            errors++;
            $display("[TB] FAIL leftover_event dut%0d ch%0d: got nothing, want %s at cycle %0d",
                     exp_q[i].dut, exp_q[i].ch, kindName(exp_q[i].kind), exp_q[i].cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
